// File: rtl/laser_peak_finder.sv
// rtl/laser_peak_finder.sv - per-row brightest laser pixel finder feeding the ZBT point writer
//
// Purpose:
//   Registers a per-pixel intensity.
//   Tracks the leftmost maximum of each active row.
//   At end of row, emits one (x, y) point as a single-cycle pulse when the
//   peak clears THRESH. Emission is gated per frame by scan_enable and is
//   capped at MAX_POINTS per frame.
//
// Optional feature (macro LASER_COLOR_SUB_EN):
//   defined   : intensity = red - ((green + blue) >> 1), saturating at 0
//   undefined : intensity = red
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_start         one-cycle strobe before the first pixel of a frame
//   scan_enable         sampled at frame_start, 1 = emit points this frame
//   pixel_valid         pixel qualifier
//   pixel_x, pixel_y    pixel coordinates
//   red, green, blue    pixel colour channels
//   point_ready_pulse   one-cycle strobe per emitted point
//   x, y                coordinates of last emitted point, held between points
//   points_this_frame   points emitted since the last frame_start
//   busy                high while scanning or emitting
module laser_peak_finder #(
    parameter int         H_ACTIVE   = 1024,
    parameter int         V_ACTIVE   = 768,
    parameter logic [7:0] THRESH     = 8'd96,
    parameter int         MAX_POINTS = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        scan_enable,
    input  logic        pixel_valid,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        point_ready_pulse,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [10:0] points_this_frame,
    output logic        busy
);

    localparam logic [10:0] LAST_COL  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] LAST_ROW  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] ROW_LIMIT = 11'(V_ACTIVE);
    localparam logic [10:0] PT_LIMIT  = 11'(MAX_POINTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Intensity pipeline stage
    logic [7:0]  intensity_d, intensity_q;
    logic [10:0] px_d, px_q;
    logic [10:0] py_d, py_q;
    logic        pv_d, pv_q;

    // Peak tracking and control
    state_t      state_d, state_q;
    logic [7:0]  max_d, max_q;
    logic [10:0] max_col_d, max_col_q;
    logic [10:0] row_d, row_q;
    logic        en_d, en_q;

    // Outputs
    logic        pulse_d, pulse_q;
    logic [10:0] x_d, x_q;
    logic [10:0] y_d, y_q;
    logic [10:0] pts_d, pts_q;

    logic        fire;

`ifdef LASER_COLOR_SUB_EN
    logic [8:0] gb_sum;
    logic [7:0] gb_half;

    always_comb begin
        gb_sum      = {1'b0, green} + {1'b0, blue};
        gb_half     = gb_sum[8:1];
        // Clamp at zero so white/background pixels cannot wrap to a bright value
        intensity_d = (red > gb_half) ? (red - gb_half) : 8'd0;
    end
`else
    logic unused_color;
    assign unused_color = ^{green, blue};

    always_comb begin
        intensity_d = red;
    end
`endif

    always_comb begin
        px_d = pixel_x;
        py_d = pixel_y;
        pv_d = pixel_valid;
    end

    assign fire = (max_q >= THRESH) && en_q && (row_q < ROW_LIMIT) && (pts_q < PT_LIMIT);

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        max_col_d = max_col_q;
        row_d     = row_q;
        en_d      = en_q;
        pulse_d   = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        pts_d     = pts_q;

        // Pixels are tracked in EMIT too, so a row that starts on the very next
        // cycle after end-of-row does not lose its first pixel.
        if (state_q != ST_IDLE && pv_q) begin
            if (px_q == 11'd0) begin
                max_d     = intensity_q;
                max_col_d = 11'd0;
            end else if (intensity_q > max_q) begin
                max_d     = intensity_q;
                max_col_d = px_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // frame_start handled below for every state
            end
            ST_SCAN: begin
                if (pv_q && px_q == LAST_COL) begin
                    row_d   = py_q;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (fire) begin
                    pulse_d = 1'b1;
                    x_d     = max_col_q;
                    y_d     = row_q;
                    pts_d   = pts_q + 11'd1;
                end
                state_d = (row_q == LAST_ROW) ? ST_IDLE : ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new frame always wins: any partial row or pending point is dropped.
        if (frame_start) begin
            en_d      = scan_enable;
            pts_d     = 11'd0;
            pulse_d   = 1'b0;
            x_d       = x_q;
            y_d       = y_q;
            max_d     = 8'd0;
            max_col_d = 11'd0;
            state_d   = ST_SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            intensity_q <= 8'd0;
            px_q        <= 11'd0;
            py_q        <= 11'd0;
            pv_q        <= 1'b0;
            state_q     <= ST_IDLE;
            max_q       <= 8'd0;
            max_col_q   <= 11'd0;
            row_q       <= 11'd0;
            en_q        <= 1'b0;
            pulse_q     <= 1'b0;
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            pts_q       <= 11'd0;
        end else begin
            intensity_q <= intensity_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pv_q        <= pv_d;
            state_q     <= state_d;
            max_q       <= max_d;
            max_col_q   <= max_col_d;
            row_q       <= row_d;
            en_q        <= en_d;
            pulse_q     <= pulse_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pts_q       <= pts_d;
        end
    end

    assign point_ready_pulse = pulse_q;
    assign x                 = x_q;
    assign y                 = y_q;
    assign points_this_frame = pts_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_laser_peak_finder.sv
// tb/tb_laser_peak_finder.sv - self-checking bench for laser_peak_finder
module tb_laser_peak_finder;

    logic        clk = 1'b0;
    logic        reset, frame_start, scan_enable, pixel_valid;
    logic [10:0] pixel_x, pixel_y;
    logic [7:0]  red, green, blue;
    logic        point_ready_pulse, busy;
    logic [10:0] x, y, points_this_frame;

    laser_peak_finder dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .scan_enable(scan_enable),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .red(red), .green(green), .blue(blue),
        .point_ready_pulse(point_ready_pulse), .x(x), .y(y),
        .points_this_frame(points_this_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    int exp_en, exp_pts, exp_x, exp_y, exp_fire, t_last;
    int rx[$], rr[$], rg[$], rb[$];

    // Writer-side observation
    int pulse_t[$];
    int pulse_y[$];
    int neg_cnt = 0, rise_cnt = 0, consec_cnt = 0, xy_glitch = 0, rst_hold = 3;
    logic        pulse_prev = 1'b0;
    logic [10:0] x_prev = 11'd0, y_prev = 11'd0;

    always @(negedge clk) begin
        neg_cnt++;
        if (point_ready_pulse === 1'b1) begin
            pulse_t.push_back(neg_cnt);
            pulse_y.push_back(int'(y));
            if (pulse_prev) consec_cnt++;
            else rise_cnt++;
        end
        if (reset === 1'b0 && rst_hold == 0 && point_ready_pulse !== 1'b1 &&
            (x !== x_prev || y !== y_prev)) xy_glitch++;
        rst_hold   = (reset !== 1'b0) ? 3 : (rst_hold > 0 ? rst_hold - 1 : 0);
        pulse_prev = (point_ready_pulse === 1'b1);
        x_prev     = x;
        y_prev     = y;
    end

    function automatic int inten(input int r, input int g, input int b);
`ifdef LASER_COLOR_SUB_EN
        int v;
        v = r - (g + b) / 2;
        return (v < 0) ? 0 : v;
`else
        return r;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int en);
        frame_start = 1'b1;
        scan_enable = en[0];
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_en  = en;
        exp_pts = 0;
    endtask

    task automatic drive_px(input int c, input int yy, input int r, input int g, input int b);
        pixel_valid = 1'b1;
        pixel_x = 11'(c); pixel_y = 11'(yy);
        red = 8'(r); green = 8'(g); blue = 8'(b);
        @(posedge clk); #1;
        pixel_valid = 1'b0;
    endtask

    task automatic clear_row();
        rx.delete(); rr.delete(); rg.delete(); rb.delete();
    endtask

    task automatic push_px(input int c, input int r, input int g, input int b);
        rx.push_back(c); rr.push_back(r); rg.push_back(g); rb.push_back(b);
    endtask

    // Sends the queued row with random valid gaps, then updates the reference
    task automatic send_row(input int yy);
        int best, bcol, iv;
        best = -1; bcol = 0;
        foreach (rx[i]) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive_px(rx[i], yy, rr[i], rg[i], rb[i]);
            iv = inten(rr[i], rg[i], rb[i]);
            if (iv > best) begin best = iv; bcol = rx[i]; end
        end
        t_last   = neg_cnt;
        exp_fire = (best >= 96 && exp_en != 0 && yy < 768 && exp_pts < 50) ? 1 : 0;
        if (exp_fire != 0) begin
            exp_pts++;
            exp_x = bcol;
            exp_y = yy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 0; scan_enable = 0; pixel_valid = 0;
        pixel_x = 0; pixel_y = 0; red = 0; green = 0; blue = 0;
        idle(3);
        checks++;
        if ({point_ready_pulse, x, y, points_this_frame, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got pulse=%0d x=%0d y=%0d pts=%0d busy=%0d, need all 0",
                     point_ready_pulse, x, y, points_this_frame, busy);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_row();
        int n0;
        start_frame(1);
        n0 = pulse_t.size();
        clear_row();
        push_px(0, 20, 0, 0); push_px(150, 20, 0, 0); push_px(300, 200, 0, 0);
        push_px(700, 20, 0, 0); push_px(1023, 20, 0, 0);
        send_row(10);
        idle(3);
        checks++;
        if (pulse_t.size() - n0 != 1) begin
            errors++; $display("FAIL single_count: got %0d pulses, need 1", pulse_t.size() - n0);
        end else begin
            checks++;
            if (pulse_t[n0] != t_last + 3) begin
                errors++; $display("FAIL single_latency: pulse at %0d, need %0d", pulse_t[n0], t_last + 3);
            end
        end
        checks++;
        if (x !== 11'd300 || y !== 11'd10) begin
            errors++; $display("FAIL single_xy: got (%0d,%0d), need (300,10)", x, y);
        end
        checks++;
        if (points_this_frame !== 11'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_pts: got pts=%0d busy=%0d, need 1 1", points_this_frame, busy);
        end
    endtask

    task automatic test_threshold();
        int n0;
        n0 = pulse_t.size();
        clear_row();
        push_px(0, 20, 0, 0); push_px(500, 95, 0, 0); push_px(1023, 20, 0, 0);
        send_row(11);
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || points_this_frame !== 11'd1) begin
            errors++; $display("FAIL thresh_95: got %0d pulses pts=%0d, need 0 pulses pts=1",
                               pulse_t.size() - n0, points_this_frame);
        end
        clear_row();
        push_px(0, 20, 0, 0); push_px(5, 96, 0, 0); push_px(600, 50, 0, 0); push_px(1023, 20, 0, 0);
        send_row(12);
        idle(3);
        checks++;
        if (pulse_t.size() - n0 != 1 || x !== 11'd5 || y !== 11'd12 || points_this_frame !== 11'd2) begin
            errors++; $display("FAIL thresh_96: got pulses=%0d x=%0d y=%0d pts=%0d, need 1 5 12 2",
                               pulse_t.size() - n0, x, y, points_this_frame);
        end
    endtask

    task automatic test_tie();
        clear_row();
        push_px(0, 20, 0, 0); push_px(100, 180, 0, 0); push_px(400, 30, 0, 0);
        push_px(700, 180, 0, 0); push_px(1023, 20, 0, 0);
        send_row(13);
        idle(3);
        checks++;
        if (x !== 11'd100 || y !== 11'd13) begin
            errors++; $display("FAIL tie_leftmost: got (%0d,%0d), need (100,13)", x, y);
        end
        clear_row();
        push_px(0, 20, 0, 0); push_px(512, 20, 0, 0); push_px(1023, 200, 0, 0);
        send_row(14);
        idle(3);
        checks++;
        if (x !== 11'd1023 || y !== 11'd14) begin
            errors++; $display("FAIL tie_lastcol: got (%0d,%0d), need (1023,14)", x, y);
        end
    endtask

    task automatic test_random_rows();
        int n0, c, hi;
        for (int row = 15; row < 35; row++) begin
            clear_row();
            hi = $urandom_range(60, 255);
            c = 0;
            while (1) begin
                push_px(c, $urandom_range(0, hi), $urandom_range(0, 255), $urandom_range(0, 255));
                if (c == 1023) break;
                c = c + $urandom_range(1, 180);
                if (c > 1023) c = 1023;
            end
            n0 = pulse_t.size();
            send_row(row);
            idle(3);
            checks++;
            if (pulse_t.size() - n0 != exp_fire || points_this_frame !== 11'(exp_pts)) begin
                errors++; $display("FAIL random_row%0d_fire: got pulses=%0d pts=%0d, need %0d %0d",
                                   row, pulse_t.size() - n0, points_this_frame, exp_fire, exp_pts);
            end
            checks++;
            if (x !== 11'(exp_x) || y !== 11'(exp_y)) begin
                errors++; $display("FAIL random_row%0d_xy: got (%0d,%0d), need (%0d,%0d)",
                                   row, x, y, exp_x, exp_y);
            end
        end
    endtask

    task automatic test_color();
        int want;
`ifdef LASER_COLOR_SUB_EN
        want = 60;
`else
        want = 50;
`endif
        start_frame(1);
        clear_row();
        push_px(0, 10, 0, 0); push_px(50, 255, 255, 255); push_px(60, 200, 40, 40);
        push_px(1023, 10, 0, 0);
        send_row(3);
        idle(3);
        checks++;
        if (x !== 11'(want) || y !== 11'd3) begin
            errors++; $display("FAIL color_peak: got (%0d,%0d), need (%0d,3)", x, y, want);
        end
    endtask

    task automatic test_abort();
        int n0;
        start_frame(1);
        n0 = pulse_t.size();
        drive_px(0, 5, 20, 0, 0);
        drive_px(200, 5, 250, 0, 0);
        start_frame(1);
        drive_px(1023, 5, 20, 0, 0);
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || points_this_frame !== 11'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_scan: got pulses=%0d pts=%0d busy=%0d, need 0 0 1",
                               pulse_t.size() - n0, points_this_frame, busy);
        end
        drive_px(0, 6, 20, 0, 0);
        drive_px(200, 6, 250, 0, 0);
        drive_px(1023, 6, 20, 0, 0);
        idle(1);
        start_frame(1);
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || points_this_frame !== 11'd0) begin
            errors++; $display("FAIL abort_emit: got pulses=%0d pts=%0d, need 0 0",
                               pulse_t.size() - n0, points_this_frame);
        end
        clear_row();
        push_px(0, 20, 0, 0); push_px(222, 240, 0, 0); push_px(1023, 20, 0, 0);
        send_row(7);
        idle(3);
        checks++;
        if (pulse_t.size() - n0 != 1 || x !== 11'd222 || points_this_frame !== 11'd1) begin
            errors++; $display("FAIL abort_restart: got pulses=%0d x=%0d pts=%0d, need 1 222 1",
                               pulse_t.size() - n0, x, points_this_frame);
        end
    endtask

    task automatic test_disabled();
        int n0;
        start_frame(0);
        scan_enable = 1'b1;
        n0 = pulse_t.size();
        for (int row = 0; row < 5; row++) begin
            clear_row();
            push_px(0, 20, 0, 0); push_px(300 + row, 250, 0, 0); push_px(1023, 20, 0, 0);
            send_row(row);
        end
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || points_this_frame !== 11'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL disabled_frame: got pulses=%0d pts=%0d busy=%0d, need 0 0 1",
                               pulse_t.size() - n0, points_this_frame, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n0, r0, peak;
        start_frame(1);
        n0 = pulse_t.size();
        r0 = rise_cnt;
        for (int row = 0; row < 768; row++) begin
            clear_row();
            peak = (row * 37) % 1000 + 1;
            push_px(0, 20, 0, 0); push_px(peak, 150, 0, 0); push_px(1023, 20, 0, 0);
            send_row(row);
        end
        idle(3);
        checks++;
        if (pulse_t.size() - n0 != 50 || rise_cnt - r0 != 50) begin
            errors++; $display("FAIL frame_cap_pulses: got pulses=%0d rises=%0d, need 50 50",
                               pulse_t.size() - n0, rise_cnt - r0);
        end else begin
            checks++;
            if (pulse_y[n0] != 0 || pulse_y[n0 + 49] != 49) begin
                errors++; $display("FAIL frame_cap_rows: got first=%0d last=%0d, need 0 49",
                                   pulse_y[n0], pulse_y[n0 + 49]);
            end
        end
        checks++;
        if (points_this_frame !== 11'd50 || busy !== 1'b0) begin
            errors++; $display("FAIL frame_cap_end: got pts=%0d busy=%0d, need 50 0", points_this_frame, busy);
        end
        checks++;
        if (x !== 11'((49 * 37) % 1000 + 1) || y !== 11'd49) begin
            errors++; $display("FAIL frame_cap_xy: got (%0d,%0d), need (%0d,49)", x, y, (49 * 37) % 1000 + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        start_frame(1);
        clear_row();
        push_px(0, 20, 0, 0); push_px(77, 220, 0, 0); push_px(1023, 20, 0, 0);
        send_row(20);
        idle(3);
        n0 = pulse_t.size();
        drive_px(0, 21, 20, 0, 0);
        drive_px(300, 21, 250, 0, 0);
        reset = 1'b1;
        drive_px(512, 21, 20, 0, 0);
        checks++;
        if ({point_ready_pulse, x, y, points_this_frame, busy} !== 35'd0) begin
            errors++; $display("FAIL reset_midrow: got pulse=%0d x=%0d y=%0d pts=%0d busy=%0d, need all 0",
                               point_ready_pulse, x, y, points_this_frame, busy);
        end
        reset = 1'b0;
        drive_px(1023, 21, 20, 0, 0);
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_midrow_after: got pulses=%0d busy=%0d, need 0 0",
                               pulse_t.size() - n0, busy);
        end
        start_frame(1);
        drive_px(0, 22, 20, 0, 0);
        drive_px(400, 22, 250, 0, 0);
        drive_px(1023, 22, 20, 0, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        checks++;
        if (pulse_t.size() != n0 || points_this_frame !== 11'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_midemit: got pulses=%0d pts=%0d busy=%0d, need 0 0 0",
                               pulse_t.size() - n0, points_this_frame, busy);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (consec_cnt != 0) begin
            errors++; $display("FAIL pulse_consecutive: got %0d back-to-back highs, need 0", consec_cnt);
        end
        checks++;
        if (xy_glitch != 0) begin
            errors++; $display("FAIL xy_hold: got %0d changes without pulse, need 0", xy_glitch);
        end
        checks++;
        if (pulse_t.size() == 0) begin
            errors++; $display("FAIL pulse_seen: got 0 pulses overall, need >0");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running, need completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_row();
        test_threshold();
        test_tie();
        test_random_rows();
        test_color();
        test_abort();
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
